svm_det_collect: RTL
====================

// Module: svm_det_collect
// PURPOSE
//  Consumes the per-window SVM score stream from the svm stage (one score per slide window, raster
//  order). Thresholds each score and merges horizontally adjacent positive windows in a row into one
//  detection (the best-scoring window). Queues detections in a FIFO for the host/overlay stage over valid/ready.
// PARAMETERS
//  FEA_I    4   integer bits of score (signed two's complement Q FEA_I.FEA_F)
//  FEA_F    28  fractional bits of score
//  SW_W     11  slide-window index width
//  SW_COLS  33  windows per row; column counter wraps here
//  DEPTH    16  detection FIFO entries (power of 2)
// PORTS
//  clk          in   1               clock
//  rst          in   1               synchronous reset, active-low
//  i_valid      in   1               score sample valid (from svm o_valid)
//  i_result     in   FEA_I+FEA_F     signed window score
//  i_sw_id      in   SW_W            window index of the sample
//  i_frame_start in  1               pulse one cycle before first sample of a frame
//  thresh       in   FEA_I+FEA_F     signed detection threshold, quasi-static
//  o_valid      out  1               FIFO head valid
//  o_ready      in   1               downstream accepts head
//  o_sw_id      out  SW_W            detection window index
//  o_score      out  FEA_I+FEA_F     detection score
//  det_cnt      out  SW_W            detections accepted into FIFO this frame
//  overflow     out  1               sticky: a detection was dropped (FIFO full)
// BEHAVIOUR
//  Reset (rst==0 at posedge): FIFO empty, state IDLE, col=0; o_valid=0, o_sw_id=0, o_score=0, det_cnt=0, overflow=0.
//  hit = i_valid && ($signed(i_result) > $signed(thresh)); equal to thresh is a miss.
//  col counter: +1 per i_valid sample, wraps SW_COLS-1 -> 0; i_frame_start forces col=0.
//  FSM states IDLE, RUN; regs best_id, best_score.
//   IDLE + hit: load best=(i_sw_id,i_result); -> RUN, unless col==SW_COLS-1: push best now, stay IDLE.
//   RUN + hit: if $signed(i_result) > best_score, replace best (tie keeps earlier window).
//   RUN + miss (i_valid, no hit): push best -> IDLE.
//   RUN + any sample at col==SW_COLS-1: update best by hit rule, then push best -> IDLE.
//   No i_valid: state, col, best hold.
//  At most one push per cycle. Push = write {best_id,best_score} at posedge ending the deciding sample's
//  cycle; o_valid rises next cycle if FIFO was empty (latency 1 cycle from deciding sample).
//  FIFO: show-ahead; o_sw_id/o_score = head when o_valid, else 0. Pop when o_valid && o_ready.
//  Push when full: accepted only if pop same cycle; otherwise dropped, overflow<=1, det_cnt unchanged.
//  Push accepted: det_cnt+1, saturating at all-ones. Push+pop same cycle: occupancy unchanged.
//  Push into empty FIFO never bypasses to outputs in the same cycle.
//  i_frame_start: clears col, det_cnt, overflow; aborts RUN (pending best discarded, no push) -> IDLE.
//   FIFO contents retained and still drained. i_frame_start and i_valid in same cycle: frame_start
//   clears first, then sample is processed as col 0.
//  Mid-operation reset: all state as reset; pending detections lost.
// CONFIGURATION
//  SVM_DET_MERGE_EN defined: run-merge FSM as above.
//  Not defined: no FSM/best regs; every hit pushed directly ({i_sw_id,i_result}) at its own cycle;
//   col counter and end-of-row rules have no effect; FIFO, det_cnt, overflow unchanged.
// TESTING
//  T1 thresh=0, o_ready=1, row scores -1,+2,+5,+3,-1 at ids 0..4 -> one entry id=2 score=+5, det_cnt=1.
//  T2 thresh=0, hits at cols 31,32 then col 0 of next row hit -> two entries (best of 31/32, then col-0 run).
//  T3 o_ready=0, 17 isolated hits -> 16 stored, overflow=1, det_cnt=16; then o_ready=1 drains 16 in order.
//  T4 RUN pending, i_frame_start pulse -> no push, det_cnt=0, overflow=0, col=0; old FIFO entries still pop.
//  T5 score == thresh -> treated as miss; equal scores +4,+4 in run -> earlier id reported.
//  T6 without SVM_DET_MERGE_EN: scores +1,+2,+3 ids 5..7 -> three entries 5,6,7; rst=0 mid-stream -> o_valid=0 next cycle.

Source files
------------

// File: rtl/svm_det_collect.sv
// svm_det_collect: thresholds per-window SVM scores, merges horizontally adjacent
// positive windows into one best-scoring detection, and queues detections for the host.
// Latency: detection enters the FIFO at the edge ending its deciding sample; o_valid one cycle later.
// Backpressure: o_valid/o_ready on the FIFO head. A push into a full FIFO with no pop is dropped
// and sets the sticky overflow flag. The input stream is never stalled.
// Ports: clk, rst (sync, active-low), i_valid/i_result/i_sw_id/i_frame_start score stream,
//        thresh, o_valid/o_ready/o_sw_id/o_score detection stream, det_cnt, overflow.
// Build option: SVM_DET_MERGE_EN enables run merging. Otherwise every hit is queued directly.

module svm_det_fifo #(
    parameter int W     = 43,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic         full,
    output logic         vld,
    output logic [W-1:0] head
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = (AW+1)'(1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          accept;
    logic          do_pop;

    assign full   = (count == (AW+1)'(DEPTH));
    assign vld    = (count != '0);
    assign head   = mem[rd_ptr];
    assign do_pop = pop && vld;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign accept = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            case ({accept, do_pop})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst && accept) mem[wr_ptr] <= push_dat;
    end
endmodule

module svm_det_collect #(
    parameter int FEA_I   = 4,
    parameter int FEA_F   = 28,
    parameter int SW_W    = 11,
    parameter int SW_COLS = 33,
    parameter int DEPTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid,
    input  logic [FEA_I+FEA_F-1:0] i_result,
    input  logic [SW_W-1:0]        i_sw_id,
    input  logic                   i_frame_start,
    input  logic [FEA_I+FEA_F-1:0] thresh,
    output logic                   o_valid,
    input  logic                   o_ready,
    output logic [SW_W-1:0]        o_sw_id,
    output logic [FEA_I+FEA_F-1:0] o_score,
    output logic [SW_W-1:0]        det_cnt,
    output logic                   overflow
);
    localparam int W = FEA_I + FEA_F;

    logic            hit;
    logic            push;
    logic [SW_W-1:0] push_id;
    logic [W-1:0]    push_score;
    logic            full;
    logic            fifo_vld;
    logic [SW_W+W-1:0] head;
    logic            drop;
    logic            accepted;
    logic [SW_W-1:0] cnt_base;

    // Equal to threshold is a miss.
    assign hit = i_valid && ($signed(i_result) > $signed(thresh));

`ifdef SVM_DET_MERGE_EN
    localparam int CW = (SW_COLS > 1) ? $clog2(SW_COLS) : 1;
    localparam logic [CW-1:0] LAST = CW'(SW_COLS - 1);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]      state;
    logic [0:0]      state_eff;
    logic [CW-1:0]   col;
    logic [CW-1:0]   col_eff;
    logic [SW_W-1:0] best_id;
    logic [W-1:0]    best_score;
    logic            last_col;
    logic            take;
    logic [SW_W-1:0] cand_id;
    logic [W-1:0]    cand_score;

    // Frame start acts before a same-cycle sample: the run is aborted and the
    // sample is seen as column 0 of an idle machine.
    always_comb begin
        state_eff  = i_frame_start ? IDLE : state;
        col_eff    = i_frame_start ? '0 : col;
        last_col   = (col_eff == LAST);
        // Strict compare keeps the earlier window on a tie.
        take       = hit && ((state_eff == IDLE) || ($signed(i_result) > $signed(best_score)));
        cand_id    = take ? i_sw_id  : best_id;
        cand_score = take ? i_result : best_score;
        if (state_eff == IDLE) push = hit && last_col;
        else                   push = i_valid && (!hit || last_col);
        push_id    = cand_id;
        push_score = cand_score;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            col        <= '0;
            best_id    <= '0;
            best_score <= '0;
        end else if (i_valid) begin
            col        <= last_col ? '0 : col_eff + CW'(1);
            best_id    <= cand_id;
            best_score <= cand_score;
            state      <= (((state_eff == IDLE) && hit) || (state_eff == RUN)) && !push ? RUN : IDLE;
        end else begin
            col   <= col_eff;
            state <= state_eff;
        end
    end
`else
    always_comb begin
        push       = hit;
        push_id    = i_sw_id;
        push_score = i_result;
    end
`endif

    svm_det_fifo #(.W(SW_W + W), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat ({push_id, push_score}),
        .pop      (o_ready),
        .full     (full),
        .vld      (fifo_vld),
        .head     (head)
    );

    assign drop     = push && full && !(o_ready && fifo_vld);
    assign accepted = push && !drop;
    assign cnt_base = i_frame_start ? '0 : det_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            det_cnt  <= '0;
            overflow <= 1'b0;
        end else begin
            if (accepted && (cnt_base != '1)) det_cnt <= cnt_base + SW_W'(1);
            else                              det_cnt <= cnt_base;
            overflow <= (i_frame_start ? 1'b0 : overflow) | drop;
        end
    end

    assign o_valid = fifo_vld;
    assign o_sw_id = fifo_vld ? head[SW_W+W-1:W] : '0;
    assign o_score = fifo_vld ? head[W-1:0]      : '0;
endmodule
